disp_timing_rd: RTL and testbench
=================================

Name: disp_timing_rd

Overview:
- Display-side consumer of the 125→25 MHz pixel FIFO that the frame-buffer read path fills.
- Runs in the pixel-clock domain. Generates 640x480@60 VGA timing and pops one RGB444 word per active pixel.
- Drives sync, data-enable and colour outputs to the VGA/HDMI encoder.
- Drives the display request back to the frame-buffer read logic.

Parameters:
- DATA_WIDTH, 12, FIFO word width; RGB444 packed as R=[11:8], G=[7:4], B=[3:0].
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, sync active level (0 = active-low).

Ports:
- i_clk  in  1  pixel clock (25 MHz)
- i_rst  in  1  synchronous active-high reset
- o_rd  out  1  FIFO read enable
- i_rdata  in  DATA_WIDTH  FIFO read data, valid 1 cycle after o_rd
- i_empty  in  1  FIFO empty flag
- o_req  out  1  display request to frame-buffer read logic
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable (active video)
- o_red  out  4  red
- o_green  out  4  green
- o_blue  out  4  blue
- o_frame_start  out  1  1-cycle pulse, aligned with the first active pixel on o_de
- o_underflow  out  1  sticky: an active pixel found the FIFO empty

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800); v_cnt 0..V_TOTAL-1 (525).
  - h_cnt wraps to 0 at H_TOTAL-1. v_cnt increments on that wrap and itself wraps at V_TOTAL-1.
  - Counter widths are $clog2 of the totals.
- Region decode, from the counter registers:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync region: the same form on v_cnt.
- Stage 0 (counter cycle): o_rd = active && !i_empty, combinational from registers. No other FIFO pop ever occurs.
- Stage 1: i_rdata is valid. active, sync and "popped" flags are carried in a delay register.
- Stage 2: outputs are registered.
  - o_de = active delayed by 2.
  - RGB = i_rdata fields if popped, else 0 (forced black during blanking and on underflow).
  - Sync outputs = sync region delayed by 2, driven at SYNC_POL when asserted.
  - Total latency from counter to pins is 2 cycles. All video outputs are mutually aligned.
- o_req, combinational from counters:
  - High when v_cnt < V_ACTIVE, or when v_cnt == V_TOTAL-1 (one-line prefill so the FIFO holds data before row 0).
  - Low for all other vertical blanking lines.
- Underflow:
  - Condition: active && i_empty.
  - Effect: no pop, pixel output black, o_underflow set to 1.
  - o_underflow holds until reset. Timing continues; there is no re-sync to the frame.
- o_frame_start: high in the single cycle where the stage-2 pixel is (h=0, v=0).
- Reset values:
  - h_cnt = v_cnt = 0.
  - o_rd = 0 while i_rst is high.
  - o_de = 0, RGB = 0, o_frame_start = 0, o_underflow = 0.
  - Sync outputs at the inactive level (~SYNC_POL); delay pipeline cleared.
- Reset mid-frame: the next cycle after release counts from (0,0); the first o_frame_start appears 2 cycles after release. Any FIFO word in flight is discarded.
- Simultaneous events: the h wrap and the v increment occur in the same cycle. Underflow on the last active pixel of a frame still sets the flag.

Optional Feature:
- Macro: DISP_TEST_PATTERN_EN.
- Defined:
  - Adds input i_test (1 bit), sampled each cycle.
  - When i_test = 1: o_rd is held 0, o_underflow is not set, and RGB shows 8 vertical colour bars of 80 px each.
  - Bar colours, in order: white, yellow, cyan, green, magenta, red, blue, black (4'hF / 4'h0 per channel).
  - Sync and DE are unchanged.
- Undefined: i_test is absent; pixels always come from the FIFO.

Decomposition:
- Package disp_pkg: the 640x480 timing localparams, H_TOTAL/V_TOTAL derivations, and the RGB444 field-slice constants.
- One natural sub-module: disp_hv_counter (h/v counters plus region decode, outputs active/hsync_reg/vsync_reg/frame-first flags).
- disp_timing_rd owns the FIFO pop, the 2-stage pipeline, underflow and the optional pattern.

Test Plan:
1. Reset, FIFO always non-empty, run 2 frames:
   - Exactly 307200 o_rd pulses per frame.
   - o_de high 640 cycles per line, 480 lines.
   - hsync low for 96 cycles starting 16 after DE falls.
   - vsync low for 2 lines; frame period 420000 cycles.
2. FIFO data = pixel index[11:0]: the pixel at (x=5, y=0) outputs R=0, G=0, B=5, appearing 2 cycles after h_cnt=5. o_frame_start coincides with the first DE.
3. Assert i_empty for 3 cycles at line 10, x=100..102:
   - No o_rd in those cycles.
   - Those pixels are black.
   - o_underflow goes 1 and stays 1 into the next frame.
4. o_req check: low during v_cnt 480..523, high at v_cnt 524 and for 0..479.
5. Assert i_rst for 1 cycle at (h=300, v=200):
   - All outputs take reset values next cycle.
   - Counting restarts at (0,0); the first o_frame_start is 2 cycles after release.
6. With DISP_TEST_PATTERN_EN defined and i_test=1:
   - o_rd is never asserted.
   - Pixel x=85 is yellow (F,F,0); x=600 is black.
   - Syncs are identical to test 1.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared 640x480@60 timing constants, RGB444 field positions and stage-1 carry record
// for the display timing/read path.
package disp_pkg;

    localparam int DISP_DATA_WIDTH = 12;
    localparam int DISP_H_ACTIVE   = 640;
    localparam int DISP_H_FP       = 16;
    localparam int DISP_H_SYNC     = 96;
    localparam int DISP_H_BP       = 48;
    localparam int DISP_V_ACTIVE   = 480;
    localparam int DISP_V_FP       = 10;
    localparam int DISP_V_SYNC     = 2;
    localparam int DISP_V_BP       = 33;
    localparam int DISP_H_TOTAL    = DISP_H_ACTIVE + DISP_H_FP + DISP_H_SYNC + DISP_H_BP;
    localparam int DISP_V_TOTAL    = DISP_V_ACTIVE + DISP_V_FP + DISP_V_SYNC + DISP_V_BP;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    localparam int NUM_BARS = 8;

    typedef struct packed {
        logic hs;
        logic vs;
        logic first;
        logic popped;
    } stage1_t;

    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        bar_rgb = {{4{~idx[1]}}, {4{~idx[2]}}, {4{~idx[0]}}};
    endfunction

endpackage

// File: rtl/disp_hv_counter.sv
// Horizontal/vertical raster counters with region decode and display request.
// DISP_TEST_PATTERN_EN adds the colour-bar index output.
module disp_hv_counter
    import disp_pkg::*;
#(
    parameter int H_ACTIVE = DISP_H_ACTIVE,
    parameter int H_FP     = DISP_H_FP,
    parameter int H_SYNC   = DISP_H_SYNC,
    parameter int H_BP     = DISP_H_BP,
    parameter int V_ACTIVE = DISP_V_ACTIVE,
    parameter int V_FP     = DISP_V_FP,
    parameter int V_SYNC   = DISP_V_SYNC,
    parameter int V_BP     = DISP_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef DISP_TEST_PATTERN_EN
    output logic [2:0] bar,
`endif
    output logic       active,
    output logic       hsync_reg,
    output logic       vsync_reg,
    output logic       frame_first,
    output logic       req
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_reg   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync_reg   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    // Last blanking line is requested too, so the FIFO is primed before row 0.
    assign req         = (v_cnt < V_ACT) || (v_cnt == V_LAST);

`ifdef DISP_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    always_comb begin
        bar = '0;
        for (int i = 1; i < NUM_BARS; i++)
            if (h_cnt >= HW'(i * BAR_W)) bar = 3'(i);
    end
`endif

endmodule

// File: rtl/disp_timing_rd.sv
// Pixel-clock VGA timing generator that pops the frame-buffer FIFO once per active pixel.
// DISP_TEST_PATTERN_EN adds i_test, which replaces FIFO pixels with colour bars.
module disp_timing_rd
    import disp_pkg::*;
#(
    parameter int   DATA_WIDTH = DISP_DATA_WIDTH,
    parameter int   H_ACTIVE   = DISP_H_ACTIVE,
    parameter int   H_FP       = DISP_H_FP,
    parameter int   H_SYNC     = DISP_H_SYNC,
    parameter int   H_BP       = DISP_H_BP,
    parameter int   V_ACTIVE   = DISP_V_ACTIVE,
    parameter int   V_FP       = DISP_V_FP,
    parameter int   V_SYNC     = DISP_V_SYNC,
    parameter int   V_BP       = DISP_V_BP,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef DISP_TEST_PATTERN_EN
    input  logic                  i_test,
`endif
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_empty,
    output logic                  o_req,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de,
    output logic [3:0]            o_red,
    output logic [3:0]            o_green,
    output logic [3:0]            o_blue,
    output logic                  o_frame_start,
    output logic                  o_underflow
);

    logic       active, hsync_reg, vsync_reg, frame_first;
    logic       test_on;
    logic [2:1] vld_pipe;
    stage1_t    s1;
    logic [11:0] pix;

`ifdef DISP_TEST_PATTERN_EN
    logic [2:0] bar, bar_s1;
    logic       pat_s1;
    assign test_on = i_test;
`else
    assign test_on = 1'b0;
`endif

    disp_hv_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_hv (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
`ifdef DISP_TEST_PATTERN_EN
        .bar        (bar),
`endif
        .active     (active),
        .hsync_reg  (hsync_reg),
        .vsync_reg  (vsync_reg),
        .frame_first(frame_first),
        .req        (o_req)
    );

    assign o_rd = active && !i_empty && !test_on && !i_rst;
    assign o_de = vld_pipe[2];

    // A pixel that was not popped is black; in test mode bars fill the active area.
    always_comb begin
        pix = '0;
        if (s1.popped)
            pix = {i_rdata[R_MSB:R_LSB], i_rdata[G_MSB:G_LSB], i_rdata[B_MSB:B_LSB]};
`ifdef DISP_TEST_PATTERN_EN
        else if (pat_s1)
            pix = bar_rgb(bar_s1);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe      <= '0;
            s1            <= '0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_frame_start <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            vld_pipe      <= {vld_pipe[1], active};
            s1            <= '{hs: hsync_reg, vs: vsync_reg, first: frame_first, popped: o_rd};
            o_hsync       <= s1.hs ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= s1.vs ? SYNC_POL : ~SYNC_POL;
            o_red         <= pix[11:8];
            o_green       <= pix[7:4];
            o_blue        <= pix[3:0];
            o_frame_start <= s1.first && vld_pipe[1];
            if (active && i_empty && !test_on)
                o_underflow <= 1'b1;
        end
    end

`ifdef DISP_TEST_PATTERN_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pat_s1 <= 1'b0;
            bar_s1 <= '0;
        end else begin
            pat_s1 <= i_test && active;
            bar_s1 <= bar;
        end
    end
`endif

endmodule

// File: tb/tb_disp_timing_rd.sv
// Bench: a scaled-down timing instance against a raster-arithmetic reference model,
// plus a default 640x480 instance checked against a vector table over the first lines.
module tb_disp_timing_rd;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst, s_rd, s_empty, s_req, s_hs, s_vs, s_de, s_fs, s_uf, s_test;
    logic [11:0] s_rdata;
    logic [3:0]  s_r, s_g, s_b;
    logic d_rst, d_rd, d_empty, d_req, d_hs, d_vs, d_de, d_fs, d_uf, d_test;
    logic [11:0] d_rdata;
    logic [3:0]  d_r, d_g, d_b;

    disp_timing_rd #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_s (
        .i_clk(clk), .i_rst(s_rst),
`ifdef DISP_TEST_PATTERN_EN
        .i_test(s_test),
`endif
        .o_rd(s_rd), .i_rdata(s_rdata), .i_empty(s_empty), .o_req(s_req),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de),
        .o_red(s_r), .o_green(s_g), .o_blue(s_b),
        .o_frame_start(s_fs), .o_underflow(s_uf)
    );

    disp_timing_rd u_d (
        .i_clk(clk), .i_rst(d_rst),
`ifdef DISP_TEST_PATTERN_EN
        .i_test(d_test),
`endif
        .o_rd(d_rd), .i_rdata(d_rdata), .i_empty(d_empty), .o_req(d_req),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de),
        .o_red(d_r), .o_green(d_g), .o_blue(d_b),
        .o_frame_start(d_fs), .o_underflow(d_uf)
    );

    int checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit de; bit hs; bit vs; bit fs; logic [11:0] rgb;
    } vout_t;

    typedef struct {
        int n; bit rd; bit de; bit hs; bit fs; logic [11:0] rgb;
    } vec_t;

    localparam int NT = 14;
    vec_t tab[NT];
    logic [11:0] bars[8];

    initial begin
        vout_t rst_out, q1, q2, nr;
        int ptot, seq, pos, x, y, f, epoch, rel_c, last_fs, rdcnt, s_ptr, d_ptr;
        bit uf_exp, rst, emp, tst, act, erd, done, rel_seen, s_rd_prev, d_rd_prev;

        // n is measured from the first cycle after reset release of the 640x480 instance.
        tab[0]  = '{-1,  0, 0, 1, 0, 12'h000};
        tab[1]  = '{0,   1, 0, 1, 0, 12'h000};
        tab[2]  = '{2,   1, 1, 1, 1, 12'h000};
        tab[3]  = '{3,   1, 1, 1, 0, 12'h001};
        tab[4]  = '{7,   1, 1, 1, 0, 12'h005};
        tab[5]  = '{639, 1, 1, 1, 0, 12'h27D};
        tab[6]  = '{640, 0, 1, 1, 0, 12'h27E};
        tab[7]  = '{641, 0, 1, 1, 0, 12'h27F};
        tab[8]  = '{642, 0, 0, 1, 0, 12'h000};
        tab[9]  = '{657, 0, 0, 1, 0, 12'h000};
        tab[10] = '{658, 0, 0, 0, 0, 12'h000};
        tab[11] = '{753, 0, 0, 0, 0, 12'h000};
        tab[12] = '{754, 0, 0, 1, 0, 12'h000};
        tab[13] = '{802, 1, 1, 1, 0, 12'h280};
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

        rst_out = '{de: 0, hs: 1, vs: 1, fs: 0, rgb: 12'h000};
        q1 = rst_out; q2 = rst_out;
        ptot = 0; seq = 0; uf_exp = 0; epoch = 0; rel_c = 3; rel_seen = 0;
        last_fs = -1; rdcnt = 0; s_ptr = 0; d_ptr = 0; done = 0;
        s_rd_prev = 0; d_rd_prev = 0;
        s_rst = 1; d_rst = 1; s_empty = 0; d_empty = 0; s_rdata = '0; d_rdata = '0;
        s_test = 0; d_test = 0;
        @(posedge clk); #1;

        while (!done && cyc < 6000) begin
            pos = ptot % FR; x = pos % HT; y = pos / HT; f = ptot / FR;

            rst = (cyc < 3) || (epoch == 0 && f == 5 && x == 10 && y == 3);
            if (epoch == 0)
                emp = (f == 2) ? (y == 3 && x >= 5 && x <= 7) :
                      (f == 3 || f == 4) ? ($urandom_range(0, 19) == 0) : 1'b0;
            else
                emp = ($urandom_range(0, 9) == 0);
`ifdef DISP_TEST_PATTERN_EN
            tst = (epoch == 1 && f >= 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
`else
            tst = 1'b0;
`endif
            s_rst = rst; s_empty = emp; s_test = tst;
            d_rst = (cyc < 3);
            if (s_rd_prev) begin s_rdata = s_ptr[11:0]; s_ptr++; end
            else s_rdata = 12'($urandom);
            if (d_rd_prev) begin d_rdata = d_ptr[11:0]; d_ptr++; end
            else d_rdata = 12'($urandom);
            #1;

            // Reference: position-derived expectations for this cycle
            act = (x < HA) && (y < VA);
            erd = !rst && act && !emp && !tst;
            chk("s_rd", s_rd, erd);
            chk("s_req", s_req, (y < VA) || (y == VT - 1));
            chk("s_de", s_de, q2.de);
            chk("s_hsync", s_hs, q2.hs);
            chk("s_vsync", s_vs, q2.vs);
            chk("s_frame_start", s_fs, q2.fs);
            chk("s_rgb", {s_r, s_g, s_b}, q2.rgb);
            chk("s_underflow", s_uf, uf_exp);

            if (epoch == 0 && f == 1) rdcnt += int'(s_rd);
            if (epoch == 0 && ptot == 2 * FR) chk("rd_per_frame", rdcnt, HA * VA);
            if (epoch == 0 && ptot == 3 * FR + HT) chk("underflow_sticky", s_uf, 1);
            if (s_fs) begin
                if (!rel_seen) begin chk("fs_after_release", cyc - rel_c, 2); rel_seen = 1; end
                else if (last_fs >= 0) chk("frame_period", cyc - last_fs, FR);
                last_fs = cyc;
            end

            for (int i = 0; i < NT; i++)
                if (tab[i].n == cyc - 3) begin
                    chk("d_rd", d_rd, tab[i].rd);
                    chk("d_de", d_de, tab[i].de);
                    chk("d_hsync", d_hs, tab[i].hs);
                    chk("d_vsync", d_vs, 1);
                    chk("d_frame_start", d_fs, tab[i].fs);
                    chk("d_rgb", {d_r, d_g, d_b}, tab[i].rgb);
                    chk("d_req", d_req, 1);
                    chk("d_underflow", d_uf, 0);
                end

            s_rd_prev = s_rd; d_rd_prev = d_rd;
            nr.de  = act;
            nr.hs  = !(x >= HA + HF && x < HA + HF + HS);
            nr.vs  = !(y >= VA + VF && y < VA + VF + VS);
            nr.fs  = (x == 0 && y == 0);
            nr.rgb = erd ? seq[11:0] : ((tst && act) ? bars[x / (HA / 8)] : 12'h000);

            if (rst) begin
                q1 = rst_out; q2 = rst_out; ptot = 0; uf_exp = 0; last_fs = -1;
                if (cyc >= 3) begin epoch = 1; rel_c = cyc + 1; rel_seen = 0; end
            end else begin
                q2 = q1; q1 = nr; ptot++;
                if (erd) seq++;
                if (act && emp && !tst) uf_exp = 1;
            end
            if (epoch == 1 && ptot == 3 * FR) done = 1;
            cyc++;
            @(posedge clk); #1;
        end

        chk("run_complete", done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
